// File: rtl/blk_accum_pkg.sv
// Shared types and helpers for the block accumulator.
// Optional build macro ACC_SPLIT_EN selects the split-carry accumulator.
package blk_accum_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int LEN_W_DEF = 8;
    localparam int LEN_MAX   = 1 << LEN_W_DEF;

    // A programmed length of zero stands for the full 2^lw samples.
    function automatic logic [31:0] len_decode(input logic [31:0] len,
                                               input int lw);
        return (len == 32'd0) ? (32'd1 << lw) : len;
    endfunction

endpackage

// File: rtl/acc_split_add.sv
// Block accumulator datapath: full-width add, or split halves with a
// registered inter-half carry when ACC_SPLIT_EN is defined.
module acc_split_add
    import blk_accum_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int ACCW  = 36
`ifdef ACC_SPLIT_EN
    , localparam int LATENCY = 2
`else
    , localparam int LATENCY = 1
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_add,
    input  logic             i_done,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_fin,
    output logic [ACCW-1:0]  o_sum,
    output logic             o_ovf
);

    logic [ACCW-1:0] w_ext;

    assign w_ext = {{(ACCW-WIDTH){1'b0}}, i_data};

`ifdef ACC_SPLIT_EN

    localparam int LO_W = ACCW / 2;
    localparam int HI_W = ACCW - LO_W;

    logic [LO_W-1:0] r_lo;
    logic [HI_W-1:0] r_hi;
    logic            r_c;
    logic            r_ovf;

    logic            r_fin;
    logic [LO_W-1:0] r_f_lo;
    logic [HI_W-1:0] r_f_hi;
    logic            r_f_c;
    logic            r_f_ovf;

    logic [LO_W:0]   w_lo_s;
    logic [HI_W:0]   w_hi_s;
    logic [LO_W-1:0] w_lo_nxt;
    logic [HI_W-1:0] w_hi_nxt;
    logic            w_c_nxt;
    logic            w_ovf_nxt;
    logic [HI_W:0]   w_fold;

    // Half-width sums; the previous low carry enters the high half now.
    always_comb begin
        w_lo_s = {1'b0, r_lo} + {1'b0, w_ext[LO_W-1:0]};
        w_hi_s = {1'b0, r_hi} + {1'b0, w_ext[ACCW-1:LO_W]}
               + {{HI_W{1'b0}}, r_c};
        if (i_load) begin
            w_lo_nxt  = w_ext[LO_W-1:0];
            w_hi_nxt  = w_ext[ACCW-1:LO_W];
            w_c_nxt   = 1'b0;
            w_ovf_nxt = 1'b0;
        end else begin
            w_lo_nxt  = w_lo_s[LO_W-1:0];
            w_hi_nxt  = w_hi_s[HI_W-1:0];
            w_c_nxt   = w_lo_s[LO_W];
            w_ovf_nxt = r_ovf | w_hi_s[HI_W];
        end
    end

    // Running split accumulator with its pending low-half carry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lo  <= '0;
            r_hi  <= '0;
            r_c   <= 1'b0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_lo  <= '0;
            r_hi  <= '0;
            r_c   <= 1'b0;
            r_ovf <= 1'b0;
        end else if (i_load || i_add) begin
            r_lo  <= w_lo_nxt;
            r_hi  <= w_hi_nxt;
            r_c   <= w_c_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    // Capture the finished block so the last carry folds in next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fin   <= 1'b0;
            r_f_lo  <= '0;
            r_f_hi  <= '0;
            r_f_c   <= 1'b0;
            r_f_ovf <= 1'b0;
        end else begin
            r_fin <= i_done;
            if (i_done) begin
                r_f_lo  <= w_lo_nxt;
                r_f_hi  <= w_hi_nxt;
                r_f_c   <= w_c_nxt;
                r_f_ovf <= w_ovf_nxt;
            end
        end
    end

    // Final carry fold of the captured block total.
    always_comb begin
        w_fold = {1'b0, r_f_hi} + {{HI_W{1'b0}}, r_f_c};
        o_fin  = r_fin;
        o_sum  = {w_fold[HI_W-1:0], r_f_lo};
        o_ovf  = r_f_ovf | w_fold[HI_W];
    end

`else

    logic [ACCW-1:0] r_acc;
    logic            r_ovf;
    logic [ACCW:0]   w_wide;
    logic [ACCW-1:0] w_nxt;
    logic            w_ovf_nxt;

    // Full-width add; a new block reloads instead of adding.
    always_comb begin
        w_wide = {1'b0, r_acc} + {1'b0, w_ext};
        if (i_load) begin
            w_nxt     = w_ext;
            w_ovf_nxt = 1'b0;
        end else begin
            w_nxt     = w_wide[ACCW-1:0];
            w_ovf_nxt = r_ovf | w_wide[ACCW];
        end
        o_fin = i_done;
        o_sum = w_nxt;
        o_ovf = w_ovf_nxt;
    end

    // Running accumulator and per-block sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_load || i_add) begin
            r_acc <= w_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

`endif

endmodule

// File: rtl/blk_accum_p.sv
// Block accumulator over the adder sum stream with a one-entry result
// register. Build macro ACC_SPLIT_EN selects the split-carry datapath.
module blk_accum_p
    import blk_accum_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int ACCW  = 36,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic [LEN_W-1:0] block_len,
    input  logic             clear,
    output logic [ACCW-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ovf,
    output logic             overrun,
    output logic             busy
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [LEN_W:0]  r_cnt;
    logic [LEN_W:0]  r_len_q;
    logic [LEN_W:0]  w_cnt_nxt;
    logic [LEN_W:0]  w_len_eff;
    logic            w_start;
    logic            w_add;
    logic            w_done;

    logic            w_fin;
    logic [ACCW-1:0] w_fin_sum;
    logic            w_fin_ovf;

    logic [ACCW-1:0] r_out_data;
    logic            r_out_valid;
    logic            r_out_ovf;
    logic            r_overrun;

    // Sample qualification; clear drops any sample in its cycle.
    always_comb begin
        w_start   = in_valid && !clear && (r_state == IDLE);
        w_add     = in_valid && !clear && (r_state == ACCUM);
        w_len_eff = w_start
                  ? (LEN_W+1)'(len_decode(32'(block_len), LEN_W))
                  : r_len_q;
        w_cnt_nxt = w_start ? (LEN_W+1)'(1) : r_cnt + 1'b1;
        w_done    = (w_start || w_add) && (w_cnt_nxt == w_len_eff);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: back to IDLE on completion or clear.
    always_comb begin
        w_state_nxt = r_state;
        if (clear)
            w_state_nxt = IDLE;
        else if (w_start || w_add)
            w_state_nxt = w_done ? IDLE : ACCUM;
    end

    // FSM outputs.
    always_comb begin
        busy = (r_state == ACCUM);
    end

    // Sample counter and latched block length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_len_q <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt   <= w_cnt_nxt;
            r_len_q <= w_len_eff;
        end else if (w_add) begin
            r_cnt <= w_cnt_nxt;
        end
    end

    acc_split_add #(
        .WIDTH (WIDTH),
        .ACCW  (ACCW)
    ) u_add (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_start),
        .i_add  (w_add),
        .i_done (w_done),
        .i_clr  (clear),
        .i_data (in_data),
        .o_fin  (w_fin),
        .o_sum  (w_fin_sum),
        .o_ovf  (w_fin_ovf)
    );

    // Holding register: new totals overwrite, overrun if still unread.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_fin) begin
            r_out_data  <= w_fin_sum;
            r_out_ovf   <= w_fin_ovf;
            r_out_valid <= 1'b1;
            if (r_out_valid && !out_ready)
                r_overrun <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ovf   = r_out_ovf;
    assign overrun   = r_overrun;

endmodule

// File: doc/blk_accum_p.md
Name: blk_accum_p

Overview:
- Downstream consumer of the team's 3-stage pipelined split-carry adder.
- Accepts the adder's unsigned sum stream with a valid strobe and accumulates blocks of block_len samples into a wider accumulator.
- Presents each block total on a ready/valid output with a one-entry holding register and overflow/overrun flags.
- Feeds block-averaging and decimation stages.

Parameters:
WIDTH, 28, input sample width (matches adder sum width)
ACCW, 36, accumulator/result width; must be >= WIDTH+1
LEN_W, 8, width of block_len and sample counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  WIDTH  unsigned sample from adder sum
in_valid  input  1  in_data valid this cycle; no backpressure to upstream
block_len  input  LEN_W  samples per block; sampled on first sample of each block; 0 means 2^LEN_W
clear  input  1  synchronous abort of the current block
out_data  output  ACCW  block total
out_valid  output  1  holding register full
out_ready  input  1  consumer accepts out_data when out_valid&&out_ready
out_ovf  output  1  block total exceeded 2^ACCW-1 (wrapped); qualifies out_data
overrun  output  1  sticky; a completed block overwrote an unaccepted result
busy  output  1  state==ACCUM

Behaviour:
- Reset (reset low, asynchronous):
  - acc, cnt, len_q, out_data = 0.
  - out_valid, out_ovf, overrun, busy = 0.
  - state = IDLE.
- FSM IDLE:
  - On in_valid: latch len_q=block_len (0 maps to 2^LEN_W), acc=in_data, cnt=1, ovf_acc=0.
  - If len_q==1, the block completes this cycle; otherwise go to ACCUM.
- FSM ACCUM:
  - On in_valid: acc=acc+in_data, with in_data zero-extended to ACCW and a carry-out of the ACCW-bit add setting ovf_acc (sticky per block).
  - Then cnt=cnt+1; completes when the incremented cnt==len_q.
  - in_valid low: hold.
- Completion:
  - Next edge: out_data=final sum (including the last sample), out_ovf=ovf_acc, out_valid=1, state=IDLE.
  - Latency is 1 cycle from the clock edge sampling the last in_valid.
  - A sample on the cycle right after completion starts a new block, with no gap cycle required.
- Output handshake:
  - out_valid clears on the edge where out_valid&&out_ready, unless a new completion occurs on the same edge. In that case the new result loads and out_valid stays 1 (no overrun).
  - Completion while out_valid=1 and out_ready=0: new result overwrites and overrun sets. overrun clears only on reset.
- clear:
  - Forces state=IDLE, cnt=0, acc=0; it has priority over in_valid that cycle, so that sample is dropped.
  - Does not touch out_data/out_valid/overrun.
  - A completion on the same cycle as clear is discarded.
- Counter wrap: cnt is LEN_W+1 bits so 2^LEN_W is representable.
- Accumulator wrap: modulo 2^ACCW, flagged via out_ovf.

Optional Feature:
Macro ACC_SPLIT_EN.
- Defined:
  - The accumulator is split into LSB half (ACCW/2) and MSB half, the same way the adder splits its operands.
  - The LSB carry is registered and added into the MSB half one cycle later.
  - Completion latency becomes 2 cycles. out_valid/out_data/out_ovf all move together, and back-to-back blocks remain supported.
- Undefined: single full-width adder, latency 1.
- Handshake, overrun and clear semantics are identical in both builds. clear also flushes the pending carry.

Decomposition:
- Package blk_accum_pkg:
  - state enum (IDLE, ACCUM);
  - localparam LEN_MAX=2^LEN_W;
  - function for len decode (0 maps to LEN_MAX).
- One natural sub-module, acc_split_add: the ACCW-bit adder. It is either full-width, or two halves with a registered carry under ACC_SPLIT_EN, and exports its latency as a parameter.

Test Plan:
- Reset mid-block:
  - block_len=4, send 2 samples, pulse reset low -> all outputs 0, busy=0.
  - Next 4 samples of 1 -> out_data=4.
- Basic block: block_len=3, in_data 10,20,30 on consecutive cycles, out_ready=1 -> out_valid high 1 cycle after the 30 is sampled, out_data=60, out_ovf=0 (2 cycles under ACC_SPLIT_EN).
- Length edge cases:
  - block_len=1 with in_data=7 -> out_data=7 next cycle.
  - block_len=0 with 256 samples of 1 (LEN_W=8) -> out_data=256.
- Overflow: ACCW=29, block_len=2, in_data=2^28-1 twice -> out_data=2^29-2 mod 2^29 = 0x1FFFFFFE, out_ovf=0. A third case, block_len=3 with three samples of 2^28-1 -> out_ovf=1.
- Backpressure:
  - out_ready=0, two back-to-back blocks of len 2 (1,1 then 5,5) -> out_data=10, overrun=1.
  - Same with out_ready pulsed coincident with the 2nd completion -> out_data=10, overrun=0.
- clear: block_len=4, samples 3,3, clear with a concurrent in_valid of 3, then 1,1,1,1 -> out_data=4, and the previous held result is unaffected.
